fifo_rx_packer: RTL

FIFO_RX_PACKER -- requirements
Module: fifo_rx_packer

---
 rtl/fifo_rx_packer.sv | 119 +++++++++++
 1 files changed

// File: rtl/fifo_rx_packer.sv
// Pops bytes from a show-ahead FIFO and packs pairs into {high, low} words with valid/ready handoff.
// Optional byte-pattern checker compiled in when FIFO_RX_SEQ_CHECK_EN is defined.
module fifo_rx_packer #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] SEQ_START = 8'd10
) (
    input  logic               rd_clk,
    input  logic               reset,
    input  logic               rd_empty,
    input  logic [WIDTH-1:0]   data_in,
    output logic               rd_en,
    output logic [2*WIDTH-1:0] word_out,
    output logic               word_valid,
    input  logic               word_ready,
    output logic [15:0]        byte_count,
    output logic               seq_err,
    output logic [7:0]         err_count
);

    typedef enum logic [1:0] {
        FILL_LO,
        FILL_HI,
        HOLD
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic             word_valid_q;
    logic [15:0]      byte_count_q;

    // Reset gates the pop so no byte is lost while the packer is being cleared.
    assign rd_en = !reset && !rd_empty && (state_q == FILL_LO || state_q == FILL_HI);

    always_ff @(posedge rd_clk) begin
        if (reset) begin
            state_q      <= FILL_LO;
            lo_q         <= '0;
            hi_q         <= '0;
            word_valid_q <= 1'b0;
            byte_count_q <= '0;
        end else begin
            if (rd_en) begin
                byte_count_q <= byte_count_q + 16'd1;
            end
            case (state_q)
                FILL_LO: begin
                    if (rd_en) begin
                        lo_q    <= data_in;
                        state_q <= FILL_HI;
                    end
                end
                FILL_HI: begin
                    if (rd_en) begin
                        hi_q         <= data_in;
                        word_valid_q <= 1'b1;
                        state_q      <= HOLD;
                    end
                end
                HOLD: begin
                    if (word_ready) begin
                        word_valid_q <= 1'b0;
                        state_q      <= FILL_LO;
                    end
                end
                default: begin
                    word_valid_q <= 1'b0;
                    state_q      <= FILL_LO;
                end
            endcase
        end
    end

    assign word_out   = {hi_q, lo_q};
    assign word_valid = word_valid_q;
    assign byte_count = byte_count_q;

`ifdef FIFO_RX_SEQ_CHECK_EN
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] exp_d;
    logic             seq_err_q;
    logic [7:0]       err_count_q;
    logic             mismatch;

    assign mismatch = (data_in != exp_q);

    // On a mismatch the checker resyncs to the received byte so one glitch counts once.
    always_comb begin
        exp_d = exp_q;
        if (rd_en) begin
            exp_d = mismatch ? data_in + WIDTH'(1) : exp_q + WIDTH'(1);
        end
    end

    always_ff @(posedge rd_clk) begin
        if (reset) begin
            exp_q       <= SEQ_START;
            seq_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            exp_q     <= exp_d;
            seq_err_q <= rd_en && mismatch;
            if (rd_en && mismatch && err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign seq_err   = seq_err_q;
    assign err_count = err_count_q;
`else
    logic unused_seq_start;

    assign unused_seq_start = ^SEQ_START;
    assign seq_err          = 1'b0;
    assign err_count        = '0;
`endif

endmodule
